div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Sequential exact signed integer divider, the inverse path to the int8 mul_unit.
//  Divides a 16-bit product-domain value by an int8 operand, e.g. for rescale or normalise steps after CMAC.
//  Radix-2 restoring algorithm, one quotient bit per clock.
//  valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//  DIVIDEND_W  16  dividend and quotient width (signed two's complement)
//  DIVISOR_W    8  divisor and remainder width (signed two's complement)
// PORTS
//  nvdla_core_clk  in   1            single clock; all state on rising edge
//  nvdla_core_rst  in   1            synchronous, active-high reset
//  in_valid        in   1            request valid
//  in_ready        out  1            request accepted when in_valid & in_ready
//  dividend        in   DIVIDEND_W   signed numerator
//  divisor         in   DIVISOR_W    signed denominator
//  out_valid       out  1            result valid
//  out_ready       in   1            result consumed when out_valid & out_ready
//  quotient        out  DIVIDEND_W   signed quotient, truncated toward zero
//  remainder       out  DIVISOR_W    signed remainder; sign follows dividend (C semantics)
//  div_zero        out  1            divisor was 0
//  ovf             out  1            quotient saturated (MIN / -1)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; quotient/remainder/div_zero/ovf=0.
//    Any op in flight is discarded.
//  FSM: IDLE -> PREP -> CALC -> DONE -> IDLE.
//    IDLE: in_ready=1. On accept, latch the sign of each operand.
//      Latch magnitudes using exact two's-complement negation, not ones' complement.
//      Magnitudes are unsigned: dividend DIVIDEND_W bits, divisor DIVISOR_W bits.
//      -32768 -> 32768 and -128 -> 128 fit unsigned.
//    PREP (1 cycle): clear partial remainder (DIVISOR_W+1 bits) and counter.
//      divisor==0: go directly to DONE with div_zero=1.
//      Otherwise go to CALC.
//    CALC (DIVIDEND_W cycles): shift {rem,q} left by 1.
//      If rem >= |divisor|: rem -= |divisor|, q[0]=1.
//      On the last step, register the sign-corrected results:
//        quotient  = sign_a^sign_b ? -q : q
//        remainder = sign_a ? -rem : rem
//      Then enter DONE.
//    DONE: out_valid=1. Outputs held stable while out_ready=0.
//      On out_ready: go to IDLE; out_valid=0 next cycle.
//  in_ready=0 in all states except IDLE; no overlap of consecutive operations.
//  Latency: accept at cycle 0 -> out_valid first high at cycle DIVIDEND_W+2 (18).
//    For div_zero: cycle 2.
//  Throughput: at best 1 op per DIVIDEND_W+3 cycles. in_ready is high again the cycle after the DONE handshake.
//  Divide by zero: quotient = dividend>=0 ? 2^(DIVIDEND_W-1)-1 : -2^(DIVIDEND_W-1).
//    remainder = dividend[DIVISOR_W-1:0]; ovf=0.
//  Overflow: dividend = -2^(DIVIDEND_W-1) and divisor = -1.
//    quotient = 2^(DIVIDEND_W-1)-1, remainder = 0, ovf=1.
//  No other overflow case is possible, since |divisor| >= 1.
//  |remainder| < |divisor| always; the remainder fits DIVISOR_W signed.
//  Flags are valid only with out_valid. They are cleared on the cycle the FSM leaves IDLE for the next op.
//  in_valid while in_ready=0 is ignored. The source must hold the request until accepted.
// STRUCTURE
//  Package div_pkg:
//    FSM state encoding (IDLE/PREP/CALC/DONE, 2 bits)
//    Counter width $clog2(DIVIDEND_W+1)
//    Saturation constants Q_MAX/Q_MIN
//  Sub-module div_step: combinational single restoring step.
//    Inputs: rem, next dividend bit, |divisor|.
//    Outputs: next rem, quotient bit.
//    Instantiated once in div_unit; lets a future multi-bit-per-cycle variant instantiate it N times.
// TESTING
//  1000 / 7 -> quotient=142, remainder=6, flags 0.
//    out_valid exactly 18 cycles after accept.
//  -1000 / 7 -> -142, -6.   1000 / -7 -> -142, 6.   -1000 / -7 -> 142, -6.
//  -32768 / -1 -> quotient=32767, remainder=0, ovf=1.
//    -32768 / -128 -> 256, 0, ovf=0.
//  5 / 0 -> quotient=32767, remainder=5, div_zero=1, latency 2.
//    -5 / 0 -> quotient=-32768, remainder=-5, div_zero=1.
//  Backpressure: hold out_ready=0 for 5 cycles in DONE.
//    Outputs stable and in_ready=0 throughout.
//    Handshake -> IDLE; next request accepted the following cycle.
//  Reset mid-CALC (cycle 9 of 127/3) -> next cycle out_valid=0, in_ready=1.
//    A subsequent 100 / 9 returns 11, 1 with normal latency.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, FSM encoding and saturation constants for div_unit
package div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    localparam logic [DIVIDEND_W-1:0] Q_MAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] Q_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W:0]   i_rem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_dvs,
    output logic [DIVISOR_W:0]   o_rem,
    output logic                 o_qbit
);

    localparam int RW = DIVISOR_W + 1;

    logic [RW:0] w_shift;

    assign w_shift = {i_rem, i_bit};
    assign o_qbit  = (w_shift >= {2'b00, i_dvs});
    assign o_rem   = o_qbit ? RW'(w_shift - {2'b00, i_dvs}) : w_shift[RW-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - sequential signed 16/8 restoring divider with valid/ready handshakes
module div_unit
    import div_pkg::*;
(
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero,
    output logic                  ovf
);

    div_state_t            r_state;
    div_state_t            w_state_nxt;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic [DIVIDEND_W-1:0] r_mag_a;
    logic [DIVISOR_W-1:0]  r_mag_b;
    logic [DIVISOR_W:0]    r_rem;
    logic [DIVIDEND_W-1:0] r_q;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_zero;
    logic                  r_ovf;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_neg_q;
    logic [DIVISOR_W:0]    w_rem_nxt;
    logic                  w_qbit;
    logic [DIVIDEND_W-1:0] w_q_nxt;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;
    assign ovf       = r_ovf;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == CNT_W'(DIVIDEND_W - 1));
    assign w_neg_q  = r_sign_a ^ r_sign_b;
    assign w_q_nxt  = {r_q[DIVIDEND_W-2:0], w_qbit};

    // Dividend bits enter the partial remainder MSB-first from the top of r_q.
    div_step u_step (
        .i_rem  (r_rem),
        .i_bit  (r_q[DIVIDEND_W-1]),
        .i_dvs  (r_mag_b),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_PREP;
            ST_PREP: w_state_nxt = (r_mag_b == '0) ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Exact negation: -32768 and -128 map to their unsigned magnitudes.
                        r_sign_a   <= dividend[DIVIDEND_W-1];
                        r_sign_b   <= divisor[DIVISOR_W-1];
                        r_mag_a    <= dividend[DIVIDEND_W-1] ? -dividend : dividend;
                        r_mag_b    <= divisor[DIVISOR_W-1]   ? -divisor  : divisor;
                        r_div_zero <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                ST_PREP: begin
                    r_rem <= '0;
                    r_cnt <= '0;
                    r_q   <= r_mag_a;
                    if (r_mag_b == '0) begin
                        r_div_zero  <= 1'b1;
                        r_quotient  <= r_sign_a ? Q_MIN : Q_MAX;
                        r_remainder <= r_sign_a ? -r_mag_a[DIVISOR_W-1:0] : r_mag_a[DIVISOR_W-1:0];
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // A positive result with the MSB set can only come from MIN / -1.
                        if (!w_neg_q && w_q_nxt[DIVIDEND_W-1]) begin
                            r_quotient <= Q_MAX;
                            r_ovf      <= 1'b1;
                        end else begin
                            r_quotient <= w_neg_q ? -w_q_nxt : w_q_nxt;
                        end
                        r_remainder <= r_sign_a ? -w_rem_nxt[DIVISOR_W-1:0] : w_rem_nxt[DIVISOR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        ovf;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .dividend       (dividend),
        .divisor        (divisor),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .quotient       (quotient),
        .remainder      (remainder),
        .div_zero       (div_zero),
        .ovf            (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the unit back in IDLE.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er,
                          input logic edz, input logic eovf, input int elat, input int hold);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        chk({tag, ".latency"}, 32'(lat), 32'(elat));
        chk({tag, ".result"}, 32'({quotient, remainder, div_zero, ovf}), 32'({eq, er, edz, eovf}));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold"}, 32'({out_valid, in_ready, quotient, remainder}),
                32'({1'b1, 1'b0, eq, er}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".release"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.in_ready",  32'(in_ready),  32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.quotient",  32'(quotient),  32'd0);
        chk("reset.remainder", 32'(remainder), 32'd0);
        chk("reset.flags",     32'({div_zero, ovf}), 32'd0);

        run_op("pos_pos",   16'd1000,     8'd7,      16'd142,      8'd6,      1'b0, 1'b0, 18, 0);
        run_op("neg_pos",   16'(-1000),   8'd7,      16'(-142),    8'(-6),    1'b0, 1'b0, 18, 0);
        run_op("pos_neg",   16'd1000,     8'(-7),    16'(-142),    8'd6,      1'b0, 1'b0, 18, 0);
        run_op("neg_neg",   16'(-1000),   8'(-7),    16'd142,      8'(-6),    1'b0, 1'b0, 18, 0);
        run_op("min_m1",    16'h8000,     8'hFF,     16'h7FFF,     8'd0,      1'b0, 1'b1, 18, 0);
        run_op("min_m128",  16'h8000,     8'h80,     16'd256,      8'd0,      1'b0, 1'b0, 18, 0);
        run_op("min_p1",    16'h8000,     8'd1,      16'h8000,     8'd0,      1'b0, 1'b0, 18, 0);
        run_op("max_p1",    16'h7FFF,     8'd1,      16'h7FFF,     8'd0,      1'b0, 1'b0, 18, 0);
        run_op("small_big", 16'd127,      8'h80,     16'd0,        8'd127,    1'b0, 1'b0, 18, 0);
        run_op("pos_zero",  16'd5,        8'd0,      16'h7FFF,     8'd5,      1'b1, 1'b0, 2,  0);
        run_op("neg_zero",  16'(-5),      8'd0,      16'h8000,     8'(-5),    1'b1, 1'b0, 2,  0);
        run_op("backpress", 16'd1000,     8'd7,      16'd142,      8'd6,      1'b0, 1'b0, 18, 5);
        run_op("after_bp",  16'(-1000),   8'd7,      16'(-142),    8'(-6),    1'b0, 1'b0, 18, 0);

        dividend = 16'd127;
        divisor  = 8'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("midcalc.busy", 32'({out_valid, in_ready}), 32'b00);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midcalc.reset", 32'({out_valid, in_ready}), 32'b01);
        run_op("post_rst",  16'd100,      8'd9,      16'd11,       8'd1,      1'b0, 1'b0, 18, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
